pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush/halt controller for the five-stage pipeline. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches/jumps, multi-cycle data-memory accesses with a timeout, and a debug halt request that drains the pipeline. It also keeps saturating stall and flush counters.

## Interface
- TIMEOUT, 16: maximum stalled cycles for one data-memory access; must be ≥ 2.
- DRAIN_CYCLES, 4: advancing cycles required to empty the pipeline on halt.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_re1, ID_re2  in  1 each  the corresponding source register is actually read.
- EX_wR  in  5  destination register of the instruction in EX.
- EX_is_load  in  1  the instruction in EX is a load.
- EX_branch_taken  in  1  a branch or jump resolved taken in EX.
- MEM_mem_req  in  1  the instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  debug halt request, level-sensitive.
- clr_cnt  in  1  synchronous clear of the counters and bus_err.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (nop, all controls 0); flush overrides the enable.
- mem_wb_bubble  out  1  MEM/WB loads a bubble (we_rf = 0).
- halt_ack  out  1  registered; 1 while in HALTED.
- bus_err  out  1  registered; sticky memory-timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  registered; saturating counters.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset values:
  - state = RUN
  - wait_cnt = 0, drain_cnt = 0
  - bus_err = 0, halt_ack = 0
  - stall_cnt = 0, flush_cnt = 0
- Enable/flush outputs are combinational from the state and inputs. Default: all enables 1, all flushes and mem_wb_bubble 0.
- Derived conditions:
  - mstall = MEM_mem_req & ~dmem_ready
  - lu = EX_is_load & (EX_wR != 0) & ((ID_re1 & ID_rs1 == EX_wR) | (ID_re2 & ID_rs2 == EX_wR))
- Priority, highest first: memory stall, branch, load-use, halt drain.
- Memory stall (RUN with mstall, or MEM_WAIT):
  - pc_en, if_id_en, id_ex_en and ex_mem_en = 0; mem_wb_en = 1 with mem_wb_bubble = 1.
  - No flushes are issued. A branch or load-use pending in EX/ID is re-evaluated after release.
  - RUN→MEM_WAIT, with wait_cnt ← 1.
  - In MEM_WAIT with ~dmem_ready and wait_cnt < TIMEOUT: stall, wait_cnt ← wait_cnt + 1.
  - In MEM_WAIT with dmem_ready: default outputs, →RUN, or →DRAIN if halt_req.
  - In MEM_WAIT with ~dmem_ready and wait_cnt == TIMEOUT: forced advance with default outputs, bus_err ← 1, →RUN.
- Branch (EX_branch_taken, no memory stall): if_id_flush = id_ex_flush = 1, pc_en = 1.
- Load-use (lu, no branch, no memory stall): pc_en = 0, if_id_en = 0, id_ex_flush = 1.
- Halt:
  - halt_req in RUN with no mstall makes that cycle the first DRAIN cycle. The state →DRAIN and drain_cnt ← 1 if the cycle is advancing, else 0.
  - DRAIN outputs: pc_en = EX_branch_taken; if_id_flush = 1, or if_id_en = 0 with no flush on load-use; the rest follow the rules above.
  - An advancing cycle is one with no memory stall and no load-use. Each advancing cycle increments drain_cnt.
  - DRAIN→HALTED on the cycle drain_cnt reaches DRAIN_CYCLES. Dropping halt_req during DRAIN does not abort the drain.
  - HALTED outputs: all enables 0 except mem_wb_en = 1 with mem_wb_bubble = 1.
  - HALTED→RUN when halt_req = 0.
- Counters:
  - stall_cnt increments on every cycle with a memory stall or load-use stall.
  - flush_cnt increments on every branch flush.
  - Both saturate at all-ones.
  - clr_cnt zeroes both counters and bus_err. When an increment and clr_cnt coincide, clr_cnt wins.

## Timing
- The enable/flush response is in the same cycle as the hazard inputs, with zero latency. The pipeline registers act at the next rising edge.
- Load-use costs exactly one bubble; the dependent instruction enters EX one cycle late.
- A branch costs two bubbles (the IF/ID and ID/EX contents are discarded).
- Memory wait: at most TIMEOUT stalled cycles; the forced advance happens in cycle TIMEOUT+1.
- halt_ack rises at the edge leaving the last drain cycle and falls one edge after halt_req = 0.
- rst_n assertion mid-operation (MEM_WAIT, DRAIN or HALTED) returns the block to RUN immediately and clears every register. The outputs then take RUN defaults.

## Test plan
- Load x5 in EX, ID reads x5 (re1 = 1) → for one cycle pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_cnt = 1. Same with EX_wR = 0 → no stall.
- EX_branch_taken together with lu → if_id_flush = id_ex_flush = 1, pc_en = 1; stall_cnt unchanged, flush_cnt = 1.
- MEM_mem_req with dmem_ready low for 3 cycles → 3 frozen cycles with mem_wb_bubble = 1, advance on cycle 4; stall_cnt = 3, bus_err = 0.
- TIMEOUT = 4, dmem_ready held 0 → stalls in cycles 1–4, forced advance in cycle 5, bus_err = 1 from cycle 6; clr_cnt → bus_err = 0.
- halt_req with no hazards → 4 cycles with pc_en = 0 and if_id_flush = 1, halt_ack = 1 after them; a load-use during the drain extends it to 5 cycles; dropping halt_req → RUN.
- rst_n pulsed low during MEM_WAIT and during HALTED → all outputs take their reset values immediately, counters = 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt controller for the five-stage pipeline: load-use, taken branch,
// multi-cycle data-memory waits with timeout, debug halt drain, and perf counters.
module pipeline_ctrl #(
    parameter int TIMEOUT      = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_re1,
    input  logic             ID_re2,
    input  logic [4:0]       EX_wR,
    input  logic             EX_is_load,
    input  logic             EX_branch_taken,
    input  logic             MEM_mem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halt_ack,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_SAT    = '1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic mstall, lu, mem_stall, timed_out, active;
    logic branch, lu_stall, drain_mode, advancing;
    logic [DRAIN_W-1:0] drain_first, drain_nxt;

    always_comb begin
        mstall = MEM_mem_req & ~dmem_ready;
        lu = EX_is_load & (EX_wR != 5'd0) &
             ((ID_re1 & (ID_rs1 == EX_wR)) | (ID_re2 & (ID_rs2 == EX_wR)));
        mem_stall = 1'b0;
        timed_out = 1'b0;
        case (state)
            RUN, DRAIN: mem_stall = mstall;
            MEM_WAIT: begin
                mem_stall = ~dmem_ready & (wait_cnt < WAIT_MAX);
                timed_out = ~dmem_ready & (wait_cnt == WAIT_MAX);
            end
            default: ;
        endcase
        active      = (state != HALTED);
        branch      = active & ~mem_stall & EX_branch_taken;
        lu_stall    = active & ~mem_stall & ~EX_branch_taken & lu;
        advancing   = active & ~mem_stall & ~lu_stall;
        // A halt accepted in RUN already behaves as the first drain cycle.
        drain_mode  = (state == DRAIN) | ((state == RUN) & halt_req & ~mstall);
        drain_first = DRAIN_W'(advancing);
        drain_nxt   = drain_cnt + DRAIN_W'(advancing);
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!active || mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (drain_mode) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            halt_ack  <= 1'b0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mstall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else if (halt_req) begin
                        if (drain_first == DRAIN_LAST) begin
                            state     <= HALTED;
                            halt_ack  <= 1'b1;
                            drain_cnt <= '0;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= drain_first;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= '0;
                        if (!timed_out && halt_req) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_nxt == DRAIN_LAST) begin
                        state     <= HALTED;
                        halt_ack  <= 1'b1;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_nxt;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state    <= RUN;
                        halt_ack <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase

            if (clr_cnt) begin
                bus_err   <= 1'b0;
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (timed_out)
                    bus_err <= 1'b1;
                if ((mem_stall || lu_stall) && stall_cnt != CNT_SAT)
                    stall_cnt <= stall_cnt + 1'b1;
                if (branch && flush_cnt != CNT_SAT)
                    flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand-written multi-cycle sequences,
// and a randomized run checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    localparam int TIMEOUT      = 4;
    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 4;
    localparam int SAT          = (1 << CNT_W) - 1;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [7:0] C_RUN    = 8'b11111_000;
    localparam logic [7:0] C_FREEZE = 8'b00001_001;
    localparam logic [7:0] C_BRANCH = 8'b11111_110;
    localparam logic [7:0] C_LU     = 8'b00111_010;
    localparam logic [7:0] C_DRAIN  = 8'b01111_100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] ID_rs1, ID_rs2, EX_wR;
    logic ID_re1, ID_re2, EX_is_load, EX_branch_taken, MEM_mem_req, dmem_ready, halt_req, clr_cnt;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble;
    logic halt_ack, bus_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0] ctl;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_re1(ID_re1), .ID_re2(ID_re2),
        .EX_wR(EX_wR), .EX_is_load(EX_is_load), .EX_branch_taken(EX_branch_taken),
        .MEM_mem_req(MEM_mem_req), .dmem_ready(dmem_ready), .halt_req(halt_req), .clr_cnt(clr_cnt),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .halt_ack(halt_ack), .bus_err(bus_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble};

    typedef struct packed {
        logic [4:0] rs1, rs2;
        logic re1, re2;
        logic [4:0] wr;
        logic ld, br, mreq, rdy, halt, clr;
    } in_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [7:0] ctl;
        int         stall;
        int         flush;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs1, input int rs2, input bit re1, input bit re2,
                               input int wr, input bit ld, input bit br, input bit mreq,
                               input bit rdy, input bit halt);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.re1 = re1; v.re2 = re2; v.wr = 5'(wr);
        v.ld = ld; v.br = br; v.mreq = mreq; v.rdy = rdy; v.halt = halt; v.clr = 1'b0;
        return v;
    endfunction

    task automatic apply(input in_t v);
        ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_re1 = v.re1; ID_re2 = v.re2; EX_wR = v.wr;
        EX_is_load = v.ld; EX_branch_taken = v.br; MEM_mem_req = v.mreq;
        dmem_ready = v.rdy; halt_req = v.halt; clr_cnt = v.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply('0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Behavioural model: classifies each cycle by what the pipeline does, then derives outputs.
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;
    localparam int A_HALTED = 0, A_FREEZE = 1, A_BRANCH = 2, A_LU = 3, A_FLOW = 4;
    int m_mode, m_waited, m_drained, m_stall, m_flush;
    bit m_bus, m_ack;
    int n_mode, n_waited, n_drained, n_stall, n_flush;
    bit n_bus, n_ack;

    task automatic model_reset();
        m_mode = M_RUN; m_waited = 0; m_drained = 0; m_stall = 0; m_flush = 0; m_bus = 0; m_ack = 0;
    endtask

    task automatic model_eval(input in_t v, output logic [7:0] e);
        bit hz_lu, frozen, draining, timeout;
        int act;
        hz_lu = v.ld && v.wr != 0 && ((v.re1 && v.rs1 == v.wr) || (v.re2 && v.rs2 == v.wr));
        frozen = 0;
        timeout = 0;
        if (m_mode == M_RUN || m_mode == M_DRAIN) frozen = v.mreq && !v.rdy;
        if (m_mode == M_WAIT) begin
            frozen  = !v.rdy && m_waited < TIMEOUT;
            timeout = !v.rdy && m_waited >= TIMEOUT;
        end
        draining = (m_mode == M_DRAIN) || (m_mode == M_RUN && v.halt && !frozen);
        if (m_mode == M_HALT) act = A_HALTED;
        else if (frozen)      act = A_FREEZE;
        else if (v.br)        act = A_BRANCH;
        else if (hz_lu)       act = A_LU;
        else                  act = A_FLOW;

        case (act)
            A_HALTED, A_FREEZE: e = C_FREEZE;
            A_BRANCH:           e = C_BRANCH;
            A_LU:               e = C_LU;
            default:            e = draining ? C_DRAIN : C_RUN;
        endcase

        n_mode = m_mode; n_waited = m_waited; n_drained = m_drained;
        n_stall = m_stall; n_flush = m_flush; n_bus = m_bus;
        case (m_mode)
            M_HALT: if (!v.halt) n_mode = M_RUN;
            M_WAIT: begin
                if (frozen) n_waited = m_waited + 1;
                else begin
                    n_waited = 0;
                    if (timeout) begin n_bus = 1; n_mode = M_RUN; end
                    else if (v.halt) begin n_mode = M_DRAIN; n_drained = 0; end
                    else n_mode = M_RUN;
                end
            end
            default: begin
                if (m_mode == M_RUN && frozen) begin
                    n_mode = M_WAIT; n_waited = 1;
                end else if (draining) begin
                    n_drained = (m_mode == M_RUN ? 0 : m_drained) +
                                ((act == A_BRANCH || act == A_FLOW) ? 1 : 0);
                    if (n_drained >= DRAIN_CYCLES) begin n_mode = M_HALT; n_drained = 0; end
                    else n_mode = M_DRAIN;
                end
            end
        endcase
        if ((act == A_FREEZE || act == A_LU) && n_stall < SAT) n_stall++;
        if (act == A_BRANCH && n_flush < SAT) n_flush++;
        if (v.clr) begin n_stall = 0; n_flush = 0; n_bus = 0; end
        n_ack = (n_mode == M_HALT);
    endtask

    task automatic model_commit();
        m_mode = n_mode; m_waited = n_waited; m_drained = n_drained;
        m_stall = n_stall; m_flush = n_flush; m_bus = n_bus; m_ack = n_ack;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        in_t idle, v;
        logic [7:0] e;
        int slow, halt_lvl;

        idle = '0;
        tbl[0]  = '{"idle",         mk(0,0,0,0,0,0,0,0,0,0), C_RUN,    0, 0};
        tbl[1]  = '{"lu_rs1",       mk(5,0,1,0,5,1,0,0,0,0), C_LU,     1, 0};
        tbl[2]  = '{"lu_wr0",       mk(0,0,1,0,0,1,0,0,0,0), C_RUN,    0, 0};
        tbl[3]  = '{"lu_rs2",       mk(1,7,0,1,7,1,0,0,0,0), C_LU,     1, 0};
        tbl[4]  = '{"lu_no_re",     mk(5,0,0,0,5,1,0,0,0,0), C_RUN,    0, 0};
        tbl[5]  = '{"load_nomatch", mk(3,4,1,1,5,1,0,0,0,0), C_RUN,    0, 0};
        tbl[6]  = '{"branch_lu",    mk(5,0,1,0,5,1,1,0,0,0), C_BRANCH, 0, 1};
        tbl[7]  = '{"mstall_prio",  mk(5,0,1,0,5,1,1,1,0,0), C_FREEZE, 1, 0};
        tbl[8]  = '{"mem_ready",    mk(0,0,0,0,0,0,0,1,1,0), C_RUN,    0, 0};
        tbl[9]  = '{"halt",         mk(0,0,0,0,0,0,0,0,0,1), C_DRAIN,  0, 0};
        tbl[10] = '{"halt_lu",      mk(2,0,1,0,2,1,0,0,0,1), C_LU,     1, 0};
        tbl[11] = '{"halt_branch",  mk(0,0,0,0,0,0,1,0,0,1), C_BRANCH, 0, 1};
        tbl[12] = '{"halt_mstall",  mk(0,0,0,0,0,0,0,1,0,1), C_FREEZE, 1, 0};

        do_reset();
        chk("reset_ctl", ctl, C_RUN);
        chk("reset_ack", halt_ack, 0);
        chk("reset_bus", bus_err, 0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_flush", flush_cnt, 0);

        for (int k = 0; k < 13; k++) begin
            do_reset();
            apply(tbl[k].i);
            #1;
            chk({"tbl_ctl_", tbl[k].name}, ctl, tbl[k].ctl);
            tick();
            apply(idle);
            chk({"tbl_stall_", tbl[k].name}, stall_cnt, tbl[k].stall);
            chk({"tbl_flush_", tbl[k].name}, flush_cnt, tbl[k].flush);
        end

        // memory wait of three stalled cycles, released on the fourth
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            apply(mk(0,0,0,0,0,0,0,1,(c == 4),0));
            #1;
            chk($sformatf("memwait_ctl_c%0d", c), ctl, (c == 4) ? C_RUN : C_FREEZE);
            tick();
        end
        apply(idle);
        chk("memwait_stall", stall_cnt, 3);
        chk("memwait_bus", bus_err, 0);

        // timeout: four stalls, forced advance in cycle 5, bus_err from cycle 6
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            apply(mk(0,0,0,0,0,0,0,1,0,0));
            #1;
            chk($sformatf("timeout_ctl_c%0d", c), ctl, (c == 5) ? C_RUN : C_FREEZE);
            chk($sformatf("timeout_bus_c%0d", c), bus_err, 0);
            tick();
        end
        apply(idle);
        chk("timeout_bus_set", bus_err, 1);
        chk("timeout_stall", stall_cnt, 4);
        v = idle; v.clr = 1'b1;
        apply(v);
        tick();
        apply(idle);
        chk("clr_bus", bus_err, 0);
        chk("clr_stall", stall_cnt, 0);

        // clean halt: four drain cycles, then HALTED until halt_req drops
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            apply(mk(0,0,0,0,0,0,0,0,0,1));
            #1;
            chk($sformatf("drain_ctl_c%0d", c), ctl, C_DRAIN);
            chk($sformatf("drain_ack_c%0d", c), halt_ack, 0);
            tick();
        end
        chk("halted_ack", halt_ack, 1);
        chk("halted_ctl", ctl, C_FREEZE);
        tick();
        chk("halted_hold", halt_ack, 1);
        apply(idle);
        #1;
        chk("halted_exit_ctl", ctl, C_FREEZE);
        tick();
        chk("run_again_ack", halt_ack, 0);
        chk("run_again_ctl", ctl, C_RUN);

        // a load-use in the second drain cycle stretches the drain to five cycles
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            apply((c == 2) ? mk(6,0,1,0,6,1,0,0,0,1) : mk(0,0,0,0,0,0,0,0,0,1));
            #1;
            chk($sformatf("drain_lu_ctl_c%0d", c), ctl, (c == 2) ? C_LU : C_DRAIN);
            chk($sformatf("drain_lu_ack_c%0d", c), halt_ack, 0);
            tick();
        end
        chk("drain_lu_ack", halt_ack, 1);
        chk("drain_lu_stall", stall_cnt, 1);

        // dropping halt_req mid-drain does not abort it
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            apply(mk(0,0,0,0,0,0,0,0,0,(c == 1)));
            #1;
            chk($sformatf("drop_ctl_c%0d", c), ctl, C_DRAIN);
            tick();
        end
        chk("drop_ack", halt_ack, 1);
        tick();
        chk("drop_exit", halt_ack, 0);

        // async reset in MEM_WAIT
        do_reset();
        apply(mk(0,0,0,0,0,0,1,0,0,0));
        tick();
        apply(mk(0,0,0,0,0,0,0,1,0,0));
        tick();
        tick();
        apply(idle);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ctl", ctl, C_RUN);
        chk("rst_wait_stall", stall_cnt, 0);
        chk("rst_wait_flush", flush_cnt, 0);
        chk("rst_wait_ack", halt_ack, 0);
        tick();
        rst_n = 1'b1;

        // async reset in HALTED
        apply(mk(0,0,0,0,0,0,0,0,0,1));
        repeat (5) tick();
        chk("pre_rst_halted", halt_ack, 1);
        apply(idle);
        rst_n = 1'b0;
        #1;
        chk("rst_halt_ack", halt_ack, 0);
        chk("rst_halt_ctl", ctl, C_RUN);
        chk("rst_halt_stall", stall_cnt, 0);
        tick();
        rst_n = 1'b1;

        // saturation and clear-wins
        apply(mk(0,0,0,0,0,0,1,0,0,0));
        repeat (SAT + 5) tick();
        chk("flush_sat", flush_cnt, SAT);
        v = mk(0,0,0,0,0,0,1,0,0,0); v.clr = 1'b1;
        apply(v);
        tick();
        apply(idle);
        chk("clr_wins_flush", flush_cnt, 0);

        // randomized run against the model
        do_reset();
        model_reset();
        slow = 0;
        halt_lvl = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) halt_lvl = !halt_lvl;
            if (slow == 0 && $urandom_range(0, 29) == 0) slow = $urandom_range(3, 7);
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.wr   = 5'($urandom_range(0, 3));
            v.re1  = 1'($urandom_range(0, 1));
            v.re2  = 1'($urandom_range(0, 1));
            v.ld   = 1'($urandom_range(0, 1));
            v.br   = ($urandom_range(0, 4) == 0);
            v.mreq = ($urandom_range(0, 3) == 0) || (slow != 0);
            v.rdy  = (slow != 0) ? 1'b0 : 1'($urandom_range(0, 1));
            v.halt = 1'(halt_lvl);
            v.clr  = ($urandom_range(0, 59) == 0);
            if (slow != 0) slow--;
            apply(v);
            #1;
            model_eval(v, e);
            chk("rnd_ctl", ctl, e);
            chk("rnd_ack", halt_ack, m_ack);
            chk("rnd_bus", bus_err, m_bus);
            chk("rnd_stall", stall_cnt, m_stall);
            chk("rnd_flush", flush_cnt, m_flush);
            tick();
            model_commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
